// File: rtl/fec_frame_pkg.sv
// fec_frame_pkg: framing constants, header layout and FSM states shared by the framer and deframer
package fec_frame_pkg;
  localparam logic [31:0] SYNC_WORD_C = 32'h1ACF_FC1D;
  localparam logic [31:0] FILL_WORD_C = 32'h0000_0000;
  localparam int PAYLOAD_WORDS_C = 16;
  localparam int FRAMES_PER_BLOCK_C = 255;
  localparam int FRAME_OVERHEAD = 3;
  localparam int HDR_BID_LSB = 16;
  localparam int HDR_FIB_LSB = 0;
  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_HDR, ST_PAY, ST_CKSUM} frm_state_e;
  function automatic int frame_len(input int payload_words);
    return payload_words + FRAME_OVERHEAD;
  endfunction
  function automatic logic [31:0] mk_hdr(input logic [15:0] bid, input logic [15:0] fib);
    return (32'(bid) << HDR_BID_LSB) | (32'(fib) << HDR_FIB_LSB);
  endfunction
endpackage

// File: rtl/frame_cksum_acc.sv
// frame_cksum_acc: running XOR of the HDR and payload words of the frame being built
module frame_cksum_acc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         acc,
  input  logic [W-1:0] d,
  output logic [W-1:0] sum
);
  always_ff @(posedge clk)
    if (rst || clr) sum <= '0;
    else if (acc) sum <= sum ^ d;
endmodule

// File: rtl/sync_framer_tx.sv
// sync_framer_tx: packs the payload stream into SYNC/HDR/PAYLOAD/CKSUM frames, filling on underrun
module sync_framer_tx
  import fec_frame_pkg::*;
#(
  parameter int W = 32,
  parameter int PAYLOAD_WORDS = PAYLOAD_WORDS_C,
  parameter int FRAMES_PER_BLOCK = FRAMES_PER_BLOCK_C,
  parameter logic [W-1:0] SYNC_WORD = W'(SYNC_WORD_C),
  parameter logic [W-1:0] FILL_WORD = W'(FILL_WORD_C)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sof,
  output logic         out_eof,
  output logic [15:0]  tx_block_id,
  output logic [15:0]  tx_frame_in_block,
  output logic [31:0]  underrun_cnt
);
  localparam int PW = $clog2(PAYLOAD_WORDS + 1);
  frm_state_e state, cur;
  logic [PW-1:0] pay_cnt;
  logic [15:0] block_id, frame_in_block;
  logic [W-1:0] sum, nxt_word;
  logic load, last_pay, last_fib;
  // IDLE with en behaves as SYNC so the sync word leaves one cycle after en rises
  always_comb begin
    cur = (state == ST_IDLE && en) ? ST_SYNC : state;
    load = cur != ST_IDLE && (!out_valid || out_ready);
    in_ready = load && state == ST_PAY;
    last_pay = pay_cnt == PW'(PAYLOAD_WORDS - 1);
    last_fib = frame_in_block == 16'(FRAMES_PER_BLOCK - 1);
    nxt_word = cur == ST_SYNC ? SYNC_WORD :
               cur == ST_HDR  ? W'(mk_hdr(block_id, frame_in_block)) :
               cur == ST_PAY  ? (in_valid ? in_data : FILL_WORD) : sum;
  end
  frame_cksum_acc #(.W(W)) u_cksum (
    .clk(clk),
    .rst(rst),
    .clr(load && cur == ST_SYNC),
    .acc(load && (cur == ST_HDR || cur == ST_PAY)),
    .d(nxt_word),
    .sum(sum)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      pay_cnt <= '0;
      block_id <= '0;
      frame_in_block <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_sof <= 1'b0;
      out_eof <= 1'b0;
      tx_block_id <= '0;
      tx_frame_in_block <= '0;
      underrun_cnt <= '0;
    end else if (load) begin
      out_data <= nxt_word;
      out_valid <= 1'b1;
      out_sof <= cur == ST_SYNC;
      out_eof <= cur == ST_CKSUM;
      state <= cur == ST_SYNC ? ST_HDR :
               cur == ST_HDR  ? ST_PAY :
               cur == ST_PAY  ? (last_pay ? ST_CKSUM : ST_PAY) :
               en ? ST_SYNC : ST_IDLE;
      pay_cnt <= (cur == ST_PAY && !last_pay) ? pay_cnt + 1'b1 : '0;
      if (cur == ST_SYNC) begin
        tx_block_id <= block_id;
        tx_frame_in_block <= frame_in_block;
      end
      // counters advance at CKSUM so HDR of the next frame already sees the new values
      if (cur == ST_CKSUM) begin
        frame_in_block <= last_fib ? '0 : frame_in_block + 1'b1;
        if (last_fib) block_id <= block_id + 1'b1;
      end
      if (cur == ST_PAY && !in_valid && underrun_cnt != '1) underrun_cnt <= underrun_cnt + 32'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule
